updown_count_sequencer: RTL and testbench
=========================================

# updown_count_sequencer

Command-driven controller that sequences a WIDTH-bit up/down counter through programmed counting runs: up-count, down-count or bounce, with a programmable limit and repeat count. Sits between a host/config interface and the counter consumers. Accepts one command per run over a valid/ready handshake and signals completion with a one-cycle `done` pulse. Supports pause and abort mid-run.

## Interface
- `WIDTH`, default 4: counter width; limit range 1..2^WIDTH-1.
- `PASS_W`, default 4: pass-count width; passes range 1..2^PASS_W-1.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  controller can accept a command; equals (state == IDLE).
- `cmd_mode`  in  2  mode: 00 = UP, 01 = DOWN, 10 = BOUNCE, 11 = reserved.
- `cmd_limit`  in  WIDTH  terminal count L.
- `cmd_passes`  in  PASS_W  number of passes P.
- `pause`  in  1  hold counter and state while in RUN.
- `abort`  in  1  terminate the run, no `done`.
- `cont`  out  WIDTH  counter value, registered.
- `dir`  out  1  0 = counting up, 1 = counting down, registered.
- `busy`  out  1  high in RUN, including while paused.
- `done`  out  1  one-cycle pulse, high in FINISH.
- `err`  out  1  one-cycle pulse when a command is rejected.

## Operation
- States: IDLE, RUN, FINISH.
- Reset values: state IDLE, `cont` 0, `dir` 0, `busy` 0, `done` 0, `err` 0, pass counter 0. `cmd_ready` reads 1 during reset.
- IDLE, handshake (`cmd_valid` & `cmd_ready`):
  - Rejected if mode is 11, L == 0 or P == 0. `err` is 1 the next cycle, state stays IDLE, `cont`/`dir` unchanged.
  - Otherwise latch mode/L/P and clear the pass counter.
  - UP or BOUNCE: `cont` <= 0, `dir` <= 0. DOWN: `cont` <= L, `dir` <= 1. Go to RUN.
- RUN, with `pause` = 0, one step per clock:
  - UP: values 0..L. At `cont` == L: if last pass, go to FINISH; else `cont` <= 0 and pass count +1.
  - DOWN: values L..0. At `cont` == 0: if last pass, go to FINISH; else `cont` <= L and pass count +1.
  - BOUNCE: 0 up to L, then down to 0; one pass = 0→L→0.
    - At `cont` == L with `dir` = 0: `dir` <= 1, `cont` <= L-1 (no dwell at L).
    - At `cont` == 0 with `dir` = 1: if last pass, go to FINISH; else `dir` <= 0, `cont` <= 1, pass count +1.
    - L = 1 gives 0,1,0,1,0...
- `pause` = 1 in RUN: `cont`, `dir`, pass count and state all hold. `pause` is ignored outside RUN.
- `abort` = 1 in RUN (priority over `pause` and over terminal detection): next state IDLE, `cont` <= 0, `dir` <= 0, no `done`, no `err`. `abort` is ignored in IDLE and FINISH.
- FINISH: lasts one cycle with `done` = 1 and `cmd_ready` = 0. `cont`/`dir` hold the final value, then state returns to IDLE.
- After FINISH, `cont` keeps its final value until the next accepted command or reset.
- Arithmetic is WIDTH-bit, unsigned. `cont` never leaves 0..L, so no wrap-around occurs.
- Asserting `rst` at any point forces the reset values on the same instant, with no `done`.

## Timing
- Accept on edge N: first count value is visible in cycle N+1.
- Run length in RUN cycles, excluding pause cycles: UP/DOWN = P·(L+1); BOUNCE = 2·L·P + 1.
- `done` is high in the cycle immediately after the final value's cycle.
- Earliest next accept is the cycle after `done`; back-to-back gap = 1 cycle (FINISH).
- `err` is high in the cycle after the rejected handshake, and `cmd_ready` stays 1 during that cycle.
- `cmd_*` inputs are sampled only on the handshake edge.

## Test plan
- UP, L=3, P=2 → `cont` 0,1,2,3,0,1,2,3; `done` pulse on the next cycle with `cont`=3; `busy` high for exactly 8 cycles.
- DOWN, L=2, P=1 → `cont` 2,1,0; `dir`=1 throughout; `done` next cycle; `cmd_ready` back to 1 the cycle after.
- BOUNCE, L=15, P=1 → `cont` 0..15..0 over 31 cycles; `dir` goes to 1 in the cycle `cont`=14; `done` follows.
- BOUNCE, L=3, P=2, `pause` high for 3 cycles while `cont`=2 → values hold 3 extra cycles; total `busy` = 13+3 cycles.
- `abort` in the cycle `cont`=2 of UP, L=5 → next cycle: IDLE, `cont`=0, no `done`, no `err`; a new command is accepted immediately.
- Commands with mode=11, L=0 and P=0 in turn → `err` pulses each time; `busy` stays 0. `rst` pulse mid-run → all outputs reset asynchronously.

Source files
------------

// File: rtl/updown_count_sequencer.sv
// updown_count_sequencer: command-driven up/down/bounce counter sequencer.
// A host hands over one run at a time (mode, terminal count, pass count) over a
// valid/ready handshake. The controller steps the counter once per clock, and
// emits a one-cycle done pulse after the final value. Pause holds a run and
// abort cancels it.
module updown_count_sequencer #(
   parameter int WIDTH  = 4,
   parameter int PASS_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_mode,
   input  logic [WIDTH-1:0]  cmd_limit,
   input  logic [PASS_W-1:0] cmd_passes,
   input  logic              pause,
   input  logic              abort,
   output logic [WIDTH-1:0]  cont,
   output logic              dir,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } state_t;

   localparam logic [1:0] MODE_UP   = 2'b00;
   localparam logic [1:0] MODE_DOWN = 2'b01;
   localparam logic [1:0] MODE_RSVD = 2'b11;

   state_t              state, state_next;
   logic [WIDTH-1:0]    cont_next;
   logic                dir_next;
   logic                err_next;
   logic [PASS_W-1:0]   pass_cnt, pass_cnt_next;
   logic [1:0]          mode, mode_next;
   logic [WIDTH-1:0]    limit, limit_next;
   logic [PASS_W-1:0]   passes, passes_next;
   logic                last_pass;

   // The pass counter counts completed passes, so the final pass is passes-1.
   assign last_pass = (pass_cnt == passes - PASS_W'(1));

   assign cmd_ready = (state == IDLE);
   assign busy      = (state == RUN);
   assign done      = (state == FINISH);

   // State, counter and latched command registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cont     <= '0;
         dir      <= 1'b0;
         err      <= 1'b0;
         pass_cnt <= '0;
         mode     <= '0;
         limit    <= '0;
         passes   <= '0;
      end else begin
         state    <= state_next;
         cont     <= cont_next;
         dir      <= dir_next;
         err      <= err_next;
         pass_cnt <= pass_cnt_next;
         mode     <= mode_next;
         limit    <= limit_next;
         passes   <= passes_next;
      end
   end

   // Next-state and counter stepping: accept/reject in IDLE, one step per RUN cycle.
   always_comb begin
      state_next    = state;
      cont_next     = cont;
      dir_next      = dir;
      err_next      = 1'b0;
      pass_cnt_next = pass_cnt;
      mode_next     = mode;
      limit_next    = limit;
      passes_next   = passes;

      case (state)
         IDLE: begin
            if (cmd_valid) begin
               if (cmd_mode == MODE_RSVD || cmd_limit == '0 || cmd_passes == '0) begin
                  err_next = 1'b1;
               end else begin
                  mode_next     = cmd_mode;
                  limit_next    = cmd_limit;
                  passes_next   = cmd_passes;
                  pass_cnt_next = '0;
                  state_next    = RUN;
                  if (cmd_mode == MODE_DOWN) begin
                     cont_next = cmd_limit;
                     dir_next  = 1'b1;
                  end else begin
                     cont_next = '0;
                     dir_next  = 1'b0;
                  end
               end
            end
         end

         RUN: begin
            if (abort) begin
               // Abort wins over pause and over end-of-run detection.
               state_next = IDLE;
               cont_next  = '0;
               dir_next   = 1'b0;
            end else if (!pause) begin
               case (mode)
                  MODE_UP: begin
                     if (cont == limit) begin
                        if (last_pass) begin
                           state_next = FINISH;
                        end else begin
                           cont_next     = '0;
                           pass_cnt_next = pass_cnt + PASS_W'(1);
                        end
                     end else begin
                        cont_next = cont + WIDTH'(1);
                     end
                  end
                  MODE_DOWN: begin
                     if (cont == '0) begin
                        if (last_pass) begin
                           state_next = FINISH;
                        end else begin
                           cont_next     = limit;
                           pass_cnt_next = pass_cnt + PASS_W'(1);
                        end
                     end else begin
                        cont_next = cont - WIDTH'(1);
                     end
                  end
                  default: begin
                     // Bounce: turn at the limit without dwelling there; a pass
                     // ends on reaching 0 while counting down.
                     if (!dir) begin
                        if (cont == limit) begin
                           dir_next  = 1'b1;
                           cont_next = limit - WIDTH'(1);
                        end else begin
                           cont_next = cont + WIDTH'(1);
                        end
                     end else begin
                        if (cont == '0) begin
                           if (last_pass) begin
                              state_next = FINISH;
                           end else begin
                              dir_next      = 1'b0;
                              cont_next     = WIDTH'(1);
                              pass_cnt_next = pass_cnt + PASS_W'(1);
                           end
                        end else begin
                           cont_next = cont - WIDTH'(1);
                        end
                     end
                  end
               endcase
            end
         end

         FINISH: begin
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_updown_count_sequencer.sv
// Testbench for updown_count_sequencer: directed scenarios followed by random
// stimulus, all checked cycle by cycle against a run-list reference model.
module tb_updown_count_sequencer;

   logic       clk;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_mode;
   logic [3:0] cmd_limit;
   logic [3:0] cmd_passes;
   logic       pause;
   logic       abort;
   logic [3:0] cont;
   logic       dir;
   logic       busy;
   logic       done;
   logic       err;

   updown_count_sequencer #(.WIDTH(4), .PASS_W(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_mode   (cmd_mode),
      .cmd_limit  (cmd_limit),
      .cmd_passes (cmd_passes),
      .pause      (pause),
      .abort      (abort),
      .cont       (cont),
      .dir        (dir),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int busy_cnt;

   // Reference model: a run is expanded into the full list of (value, dir)
   // pairs it must show; RUN cycles without pause consume one entry each.
   int m_phase;          // 0 idle, 1 run, 2 finish
   int m_cont;
   int m_dir;
   int m_err;
   int seq[$];           // entries encoded as value*2 + dir

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_phase = 0;
      m_cont  = 0;
      m_dir   = 0;
      m_err   = 0;
      seq.delete();
   endtask

   task automatic build_seq(input int mode, input int lim, input int p);
      seq.delete();
      if (mode == 0) begin
         for (int k = 0; k < p; k++)
            for (int v = 0; v <= lim; v++) seq.push_back(v * 2);
      end else if (mode == 1) begin
         for (int k = 0; k < p; k++)
            for (int v = lim; v >= 0; v--) seq.push_back(v * 2 + 1);
      end else begin
         seq.push_back(0);
         for (int k = 0; k < p; k++) begin
            for (int v = 1; v <= lim; v++) seq.push_back(v * 2);
            for (int v = lim - 1; v >= 0; v--) seq.push_back(v * 2 + 1);
         end
      end
   endtask

   task automatic pop_entry();
      int e;
      e = seq.pop_front();
      m_cont = e / 2;
      m_dir  = e % 2;
   endtask

   // Advance the model by one rising edge using the inputs currently driven.
   task automatic model_edge();
      if (rst) begin
         model_reset();
         return;
      end
      m_err = 0;
      case (m_phase)
         0: begin
            if (cmd_valid) begin
               if (cmd_mode == 2'b11 || cmd_limit == 0 || cmd_passes == 0) begin
                  m_err = 1;
               end else begin
                  build_seq(int'(cmd_mode), int'(cmd_limit), int'(cmd_passes));
                  pop_entry();
                  m_phase = 1;
               end
            end
         end
         1: begin
            if (abort) begin
               m_phase = 0;
               m_cont  = 0;
               m_dir   = 0;
               seq.delete();
            end else if (!pause) begin
               if (seq.size() == 0) m_phase = 2;
               else pop_entry();
            end
         end
         default: m_phase = 0;
      endcase
   endtask

   task automatic check_outputs();
      chk("cont",      32'(cont),      32'(m_cont));
      chk("dir",       32'(dir),       32'(m_dir));
      chk("busy",      32'(busy),      32'(m_phase == 1));
      chk("done",      32'(done),      32'(m_phase == 2));
      chk("cmd_ready", 32'(cmd_ready), 32'(m_phase == 0));
      chk("err",       32'(err),       32'(m_err));
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs();
      if (busy) busy_cnt++;
   endtask

   task automatic cycles(input int n);
      for (int k = 0; k < n; k++) cycle();
   endtask

   task automatic send(input logic [1:0] mode, input logic [3:0] lim, input logic [3:0] p);
      cmd_mode   = mode;
      cmd_limit  = lim;
      cmd_passes = p;
      cmd_valid  = 1'b1;
      cycle();
      cmd_valid  = 1'b0;
      cmd_mode   = $urandom_range(0, 3);
      cmd_limit  = $urandom_range(0, 15);
      cmd_passes = $urandom_range(0, 15);
   endtask

   initial begin
      rst        = 1'b1;
      cmd_valid  = 1'b0;
      cmd_mode   = 2'b00;
      cmd_limit  = 4'd0;
      cmd_passes = 4'd0;
      pause      = 1'b0;
      abort      = 1'b0;
      busy_cnt   = 0;
      model_reset();
      #3;
      check_outputs();
      @(negedge clk);
      rst = 1'b0;
      cycle();

      // UP L=3 P=2: eight counting cycles, then done with cont=3
      busy_cnt = 0;
      send(2'b00, 4'd3, 4'd2);
      cycles(11);
      chk("up_busy_cycles", 32'(busy_cnt), 32'd8);

      // DOWN L=2 P=1
      busy_cnt = 0;
      send(2'b01, 4'd2, 4'd1);
      cycles(5);
      chk("down_busy_cycles", 32'(busy_cnt), 32'd3);

      // BOUNCE L=15 P=1: 31 cycles
      busy_cnt = 0;
      send(2'b10, 4'd15, 4'd1);
      cycles(34);
      chk("bounce15_busy_cycles", 32'(busy_cnt), 32'd31);

      // BOUNCE L=3 P=2 with a 3-cycle pause while cont=2
      busy_cnt = 0;
      send(2'b10, 4'd3, 4'd2);
      cycles(2);
      chk("pause_at", 32'(cont), 32'd2);
      pause = 1'b1;
      cycles(3);
      pause = 1'b0;
      cycles(14);
      chk("pause_busy_cycles", 32'(busy_cnt), 32'd16);

      // Abort UP L=5 in the cont=2 cycle, then an immediate new command
      send(2'b00, 4'd5, 4'd1);
      cycles(2);
      abort = 1'b1;
      cycle();
      abort = 1'b0;
      send(2'b01, 4'd1, 4'd1);
      cycles(4);

      // Rejected commands: reserved mode, zero limit, zero passes
      send(2'b11, 4'd3, 4'd1);
      send(2'b00, 4'd0, 4'd1);
      send(2'b10, 4'd3, 4'd0);
      cycle();

      // Asynchronous reset mid-run
      send(2'b00, 4'd15, 4'd3);
      cycles(5);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_outputs();
      cycle();
      rst = 1'b0;
      cycle();

      // Random stimulus
      for (int it = 0; it < 4000; it++) begin
         cmd_valid  = ($urandom_range(0, 2) == 0);
         cmd_mode   = $urandom_range(0, 3);
         cmd_limit  = ($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
         cmd_passes = ($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom_range(1, 3));
         pause      = ($urandom_range(0, 4) == 0);
         abort      = ($urandom_range(0, 59) == 0);
         rst        = ($urandom_range(0, 599) == 0);
         cycle();
      end
      rst       = 1'b0;
      cmd_valid = 1'b0;
      pause     = 1'b0;
      abort     = 1'b0;
      cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
